// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter feeding one SDRAM controller command port.
// Read data is steered back to its requester through an in-order tag FIFO of granted port IDs.
module sdram_arbiter #(
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int MAX_RD = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_write,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ready,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_write,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ready,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic          sd_req,
  output logic          sd_write,
  output logic [AW-1:0] sd_addr,
  output logic [DW-1:0] sd_wdata,
  input  logic          sd_ready,
  input  logic          sd_rvalid,
  input  logic [DW-1:0] sd_rdata,
  output logic          rd_err
);

  localparam int IW = $clog2(MAX_RD);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(MAX_RD);

  typedef enum logic {S_IDLE, S_CMD} state_t;

  state_t        r_state;
  logic          r_last_gnt;
  logic          r_sd_req;
  logic          r_sd_write;
  logic [AW-1:0] r_sd_addr;
  logic [DW-1:0] r_sd_wdata;
  logic          r_rd_err;
  logic          r_tag_mem [MAX_RD];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_grant;
  logic          w_sel;
  logic          w_push;
  logic          w_pop;
  logic          w_head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == FULL_CNT);
  assign w_empty = (w_count == '0);

  // A read is held off while every tag slot is occupied; writes never are.
  assign w_elig0 = p0_req & (p0_write | ~w_full);
  assign w_elig1 = p1_req & (p1_write | ~w_full);
  assign w_grant = (r_state == S_IDLE) & (w_elig0 | w_elig1);
  assign w_sel   = (w_elig0 & w_elig1) ? ~r_last_gnt : w_elig1;

  // Ready is the accept strobe of the IDLE cycle; masked during reset.
  assign p0_ready = reset & w_grant & ~w_sel;
  assign p1_ready = reset & w_grant &  w_sel;

  assign w_push = r_sd_req & sd_ready & ~r_sd_write;
  assign w_pop  = sd_rvalid & ~w_empty;
  assign w_head = r_tag_mem[r_rd_ptr[IW-1:0]];

  assign p0_rvalid = w_pop & ~w_head;
  assign p1_rvalid = w_pop &  w_head;
  assign p0_rdata  = sd_rdata;
  assign p1_rdata  = sd_rdata;

  assign sd_req   = r_sd_req;
  assign sd_write = r_sd_write;
  assign sd_addr  = r_sd_addr;
  assign sd_wdata = r_sd_wdata;
  assign rd_err   = r_rd_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sd_req   <= 1'b0;
      r_sd_write <= 1'b0;
      r_sd_addr  <= '0;
      r_sd_wdata <= '0;
      r_last_gnt <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state    <= S_CMD;
            r_sd_req   <= 1'b1;
            r_last_gnt <= w_sel;
            r_sd_write <= w_sel ? p1_write : p0_write;
            r_sd_addr  <= w_sel ? p1_addr  : p0_addr;
            r_sd_wdata <= w_sel ? p1_wdata : p0_wdata;
          end
        end
        S_CMD: begin
          if (sd_ready) begin
            r_state  <= S_IDLE;
            r_sd_req <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_sd_req <= 1'b0;
        end
      endcase
    end
  end

  // Tag pushed is the port of the command in flight, which is last_gnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < MAX_RD; i++) begin
        r_tag_mem[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_tag_mem[r_wr_ptr[IW-1:0]] <= r_last_gnt;
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_err <= 1'b0;
    end else if (sd_rvalid && w_empty) begin
      r_rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: round-robin, stall hold, tag-FIFO backpressure,
// read steering, orphan read data and asynchronous reset mid-command.
module tb_sdram_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_write, p0_ready, p0_rvalid;
  logic [23:0] p0_addr;
  logic [15:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_write, p1_ready, p1_rvalid;
  logic [23:0] p1_addr;
  logic [15:0] p1_wdata, p1_rdata;
  logic        sd_req, sd_write, sd_ready, sd_rvalid, rd_err;
  logic [23:0] sd_addr;
  logic [15:0] sd_wdata, sd_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sdram_arbiter #(.AW(24), .DW(16), .MAX_RD(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sd_req(sd_req), .sd_write(sd_write), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
    .sd_ready(sd_ready), .sd_rvalid(sd_rvalid), .sd_rdata(sd_rdata), .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  // Inputs change at posedge+1, outputs are checked at the following negedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    p0_req = 1'b1; p0_write = 1'b1; p0_addr = 24'h0; p0_wdata = 16'h0;
    p1_req = 1'b0; p1_write = 1'b0; p1_addr = 24'h0; p1_wdata = 16'h0;
    sd_ready = 1'b0; sd_rvalid = 1'b0; sd_rdata = 16'h0;
    #2;
    chk("rst_sd_req",   32'(sd_req),   0);
    chk("rst_p0_ready", 32'(p0_ready), 0);
    chk("rst_rd_err",   32'(rd_err),   0);
    chk("rst_sd_addr",  32'(sd_addr),  0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 0);
    step();

    // Round-robin: both ports write continuously, controller always ready.
    reset = 1'b1;
    p0_req = 1'b1; p0_write = 1'b1; p0_addr = 24'h000100; p0_wdata = 16'hA0A0;
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 24'h000200; p1_wdata = 16'hB1B1;
    sd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("rr_p0_ready", 32'(p0_ready), 32'(k % 2 == 0));
      chk("rr_p1_ready", 32'(p1_ready), 32'(k % 2 == 1));
      chk("rr_idle_sd_req", 32'(sd_req), 0);
      step();
      if (k == 3) begin
        p0_req = 1'b0; p1_req = 1'b0;
      end
      mid();
      chk("rr_sd_req", 32'(sd_req), 1);
      chk("rr_sd_addr", 32'(sd_addr), (k % 2 == 0) ? 32'h100 : 32'h200);
      chk("rr_cmd_noready", 32'(p0_ready | p1_ready), 0);
      step();
    end

    // Stalled write from p1 holds the command for six cycles.
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 24'h000010; p1_wdata = 16'hBEEF;
    sd_ready = 1'b0;
    mid();
    chk("stall_grant_p1", 32'(p1_ready), 1);
    chk("stall_p0_ready", 32'(p0_ready), 0);
    step();
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        sd_ready = 1'b1; p1_req = 1'b0;
      end
      mid();
      chk("stall_sd_req",   32'(sd_req),   1);
      chk("stall_sd_addr",  32'(sd_addr),  32'h10);
      chk("stall_sd_wdata", 32'(sd_wdata), 32'hBEEF);
      chk("stall_no_ready", 32'(p1_ready), 0);
      step();
    end
    mid();
    chk("stall_back_idle", 32'(sd_req), 0);
    step();

    // Four p0 reads fill the tag FIFO.
    p0_req = 1'b1; p0_write = 1'b0; sd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      p0_addr = 24'(32'h40 + k);
      mid();
      chk("fill_p0_ready", 32'(p0_ready), 1);
      step();
      mid();
      chk("fill_sd_write", 32'(sd_write), 0);
      chk("fill_sd_addr", 32'(sd_addr), 32'h40 + k);
      step();
    end
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 24'h000300; p1_wdata = 16'h1234;
    mid();
    chk("full_p0_blocked", 32'(p0_ready), 0);
    chk("full_p1_write_ok", 32'(p1_ready), 1);
    step();
    p1_req = 1'b0;
    mid();
    chk("full_wr_addr", 32'(sd_addr), 32'h300);
    step();
    sd_rvalid = 1'b1; sd_rdata = 16'h5555;
    mid();
    chk("full_still_blocked", 32'(p0_ready), 0);
    chk("full_pop_p0_rvalid", 32'(p0_rvalid), 1);
    chk("full_pop_p1_rvalid", 32'(p1_rvalid), 0);
    chk("full_pop_p0_rdata", 32'(p0_rdata), 32'h5555);
    chk("full_pop_p1_rdata", 32'(p1_rdata), 32'h5555);
    step();
    sd_rvalid = 1'b0;
    mid();
    chk("after_pop_p0_ready", 32'(p0_ready), 1);
    step();
    p0_req = 1'b0;
    mid();
    chk("after_pop_sd_addr", 32'(sd_addr), 32'h43);
    step();
    for (int k = 0; k < 4; k++) begin
      sd_rvalid = 1'b1; sd_rdata = 16'(32'h6000 + k);
      mid();
      chk("drain_p0_rvalid", 32'(p0_rvalid), 1);
      chk("drain_p1_rvalid", 32'(p1_rvalid), 0);
      step();
    end
    sd_rvalid = 1'b0;

    // Reads p0,p1,p0; first return overlaps the third read's acceptance.
    p0_req = 1'b1; p0_write = 1'b0; p0_addr = 24'h000080;
    mid();
    chk("ord_gnt_p0a", 32'(p0_ready), 1);
    step();
    p0_req = 1'b0;
    mid();
    step();
    p1_req = 1'b1; p1_write = 1'b0; p1_addr = 24'h000090;
    mid();
    chk("ord_gnt_p1", 32'(p1_ready), 1);
    step();
    p1_req = 1'b0;
    mid();
    step();
    p0_req = 1'b1; p0_addr = 24'h0000A0;
    mid();
    chk("ord_gnt_p0b", 32'(p0_ready), 1);
    step();
    p0_req = 1'b0; sd_rvalid = 1'b1; sd_rdata = 16'h1111;
    mid();
    chk("ord_1111_p0_rvalid", 32'(p0_rvalid), 1);
    chk("ord_1111_p1_rvalid", 32'(p1_rvalid), 0);
    chk("ord_1111_rdata", 32'(p0_rdata), 32'h1111);
    step();
    sd_rdata = 16'h2222;
    mid();
    chk("ord_2222_p1_rvalid", 32'(p1_rvalid), 1);
    chk("ord_2222_p0_rvalid", 32'(p0_rvalid), 0);
    chk("ord_2222_rdata", 32'(p1_rdata), 32'h2222);
    step();
    sd_rdata = 16'h3333;
    mid();
    chk("ord_3333_p0_rvalid", 32'(p0_rvalid), 1);
    chk("ord_3333_p1_rvalid", 32'(p1_rvalid), 0);
    chk("ord_3333_rdata", 32'(p0_rdata), 32'h3333);
    step();

    // Orphan read data: dropped and flagged.
    sd_rdata = 16'h7777;
    mid();
    chk("orphan_p0_rvalid", 32'(p0_rvalid), 0);
    chk("orphan_p1_rvalid", 32'(p1_rvalid), 0);
    chk("orphan_err_before", 32'(rd_err), 0);
    step();
    sd_rvalid = 1'b0;
    mid();
    chk("orphan_err_set", 32'(rd_err), 1);
    step();
    step();
    mid();
    chk("orphan_err_sticky", 32'(rd_err), 1);
    step();

    // One read outstanding, then a write stalled in CMD when reset hits.
    p0_req = 1'b1; p0_write = 1'b0; p0_addr = 24'h0000C0;
    mid();
    chk("rst_pre_gnt_p0", 32'(p0_ready), 1);
    step();
    p0_req = 1'b0;
    mid();
    step();
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 24'h0000D0; p1_wdata = 16'h0D0D;
    sd_ready = 1'b0;
    mid();
    chk("rst_pre_gnt_p1", 32'(p1_ready), 1);
    step();
    p1_req = 1'b0;
    mid();
    chk("rst_pre_in_cmd", 32'(sd_req), 1);
    #2;
    reset = 1'b0;
    sd_rvalid = 1'b1;
    p0_req = 1'b1; p0_write = 1'b1; p0_addr = 24'h0000E0;
    p1_req = 1'b1; p1_write = 1'b1; p1_addr = 24'h0000F0;
    #1;
    chk("async_sd_req", 32'(sd_req), 0);
    chk("async_sd_addr", 32'(sd_addr), 0);
    chk("async_sd_wdata", 32'(sd_wdata), 0);
    chk("async_rd_err", 32'(rd_err), 0);
    chk("async_fifo_empty", 32'(p0_rvalid), 0);
    chk("async_no_ready", 32'(p0_ready | p1_ready), 0);
    step();
    step();
    reset = 1'b1; sd_rvalid = 1'b0; sd_ready = 1'b1;
    mid();
    chk("post_rst_gnt_p0", 32'(p0_ready), 1);
    chk("post_rst_p1_wait", 32'(p1_ready), 0);
    step();
    p0_req = 1'b0; p1_req = 1'b0;
    mid();
    chk("post_rst_sd_addr", 32'(sd_addr), 32'hE0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
